// File: rtl/mirfak_id_stage_hs_pkg.sv
// Shared decode-stage definitions: control word layout, operand select codes,
// exception causes and the EX payload carried through the skid buffer.
package mirfak_id_stage_hs_pkg;

  localparam logic [31:0] NOP                    = 32'h0000_0013;
  localparam logic [3:0]  E_INST_ADDR_MISALIGNED = 4'd0;
  localparam logic [3:0]  E_ILLEGAL_INST         = 4'd2;
  localparam int unsigned FWD_RF                 = 0;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;
  typedef enum logic [1:0] {A_REG, A_PC, A_ZERO} a_sel_e;
  typedef enum logic [1:0] {B_REG, B_IMM, B_4} b_sel_e;

  typedef struct packed {
    logic     illegal;
    logic     branch;
    logic     jal;
    logic     jalr;
    imm_sel_e imm_sel;
    a_sel_e   a_sel;
    b_sel_e   b_sel;
    logic [3:0] alu_op;
  } ctrl_t;

  localparam int unsigned CTRL_SZ = $bits(ctrl_t);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instruction;
    logic [31:0] mtval;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] lsu_wdata;
    logic        exception;
    logic [3:0]  xcause;
    ctrl_t       control;
  } payload_t;

  localparam payload_t PAYLOAD_RST =
    payload_t'({64'd0, NOP, 128'd0, 1'b0, 4'd0, ctrl_t'('0)});

  function automatic logic [31:0] imm_decode(input imm_sel_e sel, input logic [31:0] i);
    case (sel)
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   return {i[31:12], 12'b0};
      IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return {{20{i[31]}}, i[31:20]};
    endcase
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mirfak_id_stage_hs_regfile.sv
// 32x32 register file, x0 hard-wired to zero, two asynchronous read ports.
module mirfak_register_file (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  raddr_a_i,
  output logic [31:0] rdata_a_o,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_b_o,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic        wen_i
);

  logic [31:0] regs [32];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wen_i && (waddr_i != 5'd0)) begin
      regs[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs[raddr_a_i];
  assign rdata_b_o = regs[raddr_b_i];

endmodule

// File: rtl/mirfak_id_stage_hs_skid.sv
// Two-entry skid buffer: main register drives the consumer, the skid entry
// absorbs the one transfer already in flight when the consumer stalls.
module mirfak_skid_buffer #(
  parameter int unsigned W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         main_v, skid_v;
  logic [W-1:0] main_d, skid_d;
  logic         accept, handoff;

  assign accept  = in_valid_i && !skid_v;
  assign handoff = main_v && out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= RST_VAL;
      skid_d <= RST_VAL;
    end else if (clear_i) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (handoff && skid_v) begin
      // skid full implies ready was low, so no accept can coincide here
      main_d <= skid_d;
      skid_v <= 1'b0;
    end else if (accept && (!main_v || handoff)) begin
      main_d <= in_data_i;
      main_v <= 1'b1;
    end else if (accept) begin
      skid_d <= in_data_i;
      skid_v <= 1'b1;
    end else if (handoff) begin
      main_v <= 1'b0;
    end
  end

  assign in_ready_o  = !skid_v;
  assign out_valid_o = main_v;
  assign out_data_o  = main_d;

endmodule

// File: rtl/mirfak_id_stage_hs.sv
// Decode stage: immediates, RF read with N-way forwarding, branch resolution,
// ID exceptions, handing the payload to EX through a valid/ready skid buffer.
module mirfak_id_stage_hs
  import mirfak_id_stage_hs_pkg::*;
#(
  parameter int unsigned NFWD    = 2,
  parameter int unsigned HAS_RVC = 0,
  parameter int unsigned BJ_REG  = 0,
  localparam int unsigned FSW    = $clog2(NFWD + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               id_valid_i,
  output logic               id_ready_o,
  input  logic [31:0]        id_pc_i,
  input  logic [31:0]        id_pc4_i,
  input  logic [31:0]        id_instruction_i,
  input  logic               id_if_exception_i,
  input  logic [3:0]         id_if_xcause_i,
  input  logic [CTRL_SZ-1:0] id_control_i,
  input  logic [FSW-1:0]     id_fwd_a_sel_i,
  input  logic [FSW-1:0]     id_fwd_b_sel_i,
  input  logic [NFWD*32-1:0] fwd_data_i,
  input  logic [4:0]         wb_waddr_i,
  input  logic [31:0]        wb_wdata_i,
  input  logic               wb_wen_i,
  input  logic               idex_clear_i,
  output logic               ex_valid_o,
  input  logic               ex_ready_i,
  output logic [31:0]        ex_pc_o,
  output logic [31:0]        ex_pc4_o,
  output logic [31:0]        ex_instruction_o,
  output logic [31:0]        ex_mtval_o,
  output logic [31:0]        ex_operand_a_o,
  output logic [31:0]        ex_operand_b_o,
  output logic [31:0]        ex_lsu_wdata_o,
  output logic               ex_exception_o,
  output logic [3:0]         ex_xcause_o,
  output logic [CTRL_SZ-1:0] ex_control_o,
  output logic               take_branch_o,
  output logic [31:0]        pc_bj_target_o
);

  ctrl_t       ctrl;
  logic [31:0] rf_a, rf_b, rs1_val, rs2_val, imm, bj_target;
  logic        bj_taken, bj_misalign, accept, fire;
  payload_t    id_pl, ex_pl;

  assign ctrl = ctrl_t'(id_control_i);

  mirfak_register_file u_rf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .raddr_a_i (id_instruction_i[19:15]),
    .rdata_a_o (rf_a),
    .raddr_b_i (id_instruction_i[24:20]),
    .rdata_b_o (rf_b),
    .waddr_i   (wb_waddr_i),
    .wdata_i   (wb_wdata_i),
    .wen_i     (wb_wen_i)
  );

  always_comb begin
    rs1_val = 'x;
    rs2_val = 'x;
    if (id_fwd_a_sel_i == FSW'(FWD_RF)) rs1_val = rf_a;
    if (id_fwd_b_sel_i == FSW'(FWD_RF)) rs2_val = rf_b;
    for (int unsigned k = 1; k <= NFWD; k++) begin
      if (id_fwd_a_sel_i == FSW'(k)) rs1_val = fwd_data_i[32*(k-1) +: 32];
      if (id_fwd_b_sel_i == FSW'(k)) rs2_val = fwd_data_i[32*(k-1) +: 32];
    end
  end

  assign imm       = imm_decode(ctrl.imm_sel, id_instruction_i);
  assign bj_target = ctrl.jalr ? ((rs1_val + imm) & ~32'd1) : (id_pc_i + imm);
  assign bj_taken  = ctrl.jal || ctrl.jalr ||
                     (ctrl.branch && br_taken(id_instruction_i[14:12], rs1_val, rs2_val));
  // with RVC only the LSB matters, checked after the JALR clear
  assign bj_misalign = bj_taken && ((HAS_RVC != 0) ? bj_target[0] : (|bj_target[1:0]));

  always_comb begin
    id_pl             = PAYLOAD_RST;
    id_pl.pc          = id_pc_i;
    id_pl.pc4         = id_pc4_i;
    id_pl.instruction = id_instruction_i;
    id_pl.lsu_wdata   = rs2_val;
    id_pl.control     = ctrl;
    id_pl.exception   = 1'b1;
    case (ctrl.a_sel)
      A_REG:   id_pl.operand_a = rs1_val;
      A_PC:    id_pl.operand_a = id_pc_i;
      default: id_pl.operand_a = '0;
    endcase
    case (ctrl.b_sel)
      B_REG:   id_pl.operand_b = rs2_val;
      B_IMM:   id_pl.operand_b = imm;
      B_4:     id_pl.operand_b = 32'd4;
      default: id_pl.operand_b = '0;
    endcase
    if (id_if_exception_i) begin
      id_pl.xcause = id_if_xcause_i;
      id_pl.mtval  = id_pc_i;
    end else if (bj_misalign) begin
      id_pl.xcause = E_INST_ADDR_MISALIGNED;
      id_pl.mtval  = bj_target;
    end else if (ctrl.illegal) begin
      id_pl.xcause = E_ILLEGAL_INST;
      id_pl.mtval  = id_instruction_i;
    end else begin
      id_pl.exception = 1'b0;
    end
  end

  mirfak_skid_buffer #(
    .W       ($bits(payload_t)),
    .RST_VAL (PAYLOAD_RST)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (idex_clear_i),
    .in_valid_i  (id_valid_i),
    .in_ready_o  (id_ready_o),
    .in_data_i   (id_pl),
    .out_valid_o (ex_valid_o),
    .out_ready_i (ex_ready_i),
    .out_data_o  (ex_pl)
  );

  assign ex_pc_o          = ex_pl.pc;
  assign ex_pc4_o         = ex_pl.pc4;
  assign ex_instruction_o = ex_pl.instruction;
  assign ex_mtval_o       = ex_pl.mtval;
  assign ex_operand_a_o   = ex_pl.operand_a;
  assign ex_operand_b_o   = ex_pl.operand_b;
  assign ex_lsu_wdata_o   = ex_pl.lsu_wdata;
  assign ex_exception_o   = ex_pl.exception;
  assign ex_xcause_o      = ex_pl.xcause;
  assign ex_control_o     = ex_pl.control;

  assign accept = id_valid_i && id_ready_o;
  assign fire   = accept && bj_taken && !idex_clear_i;

  if (BJ_REG != 0) begin : g_bj_reg
    logic        take_q;
    logic [31:0] target_q;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        take_q   <= 1'b0;
        target_q <= '0;
      end else begin
        take_q <= fire;
        if (fire) target_q <= bj_target;
      end
    end
    assign take_branch_o  = take_q;
    assign pc_bj_target_o = target_q;
  end else begin : g_bj_comb
    assign take_branch_o  = fire;
    assign pc_bj_target_o = fire ? bj_target : '0;
  end

endmodule

// File: tb/tb_mirfak_id_stage_hs.sv
// Drives two configurations of the decode stage with identical stimulus and
// checks both against a transaction-level model of decode and the skid queue.
module tb_mirfak_id_stage_hs;
  import mirfak_id_stage_hs_pkg::*;

  localparam int unsigned NFWD = 3;

  logic               clk = 1'b0;
  logic               rst, id_valid, if_exc, clear, ex_ready, wb_wen;
  logic [3:0]         if_xc;
  logic [31:0]        pc, pc4, instr, wb_wdata;
  logic [4:0]         wb_waddr;
  logic [CTRL_SZ-1:0] ctrl;
  logic [1:0]         sel_a, sel_b;
  logic [NFWD*32-1:0] fwd;

  logic               a_rdy, a_vld, a_exc, a_take;
  logic [31:0]        a_pc, a_pc4, a_ins, a_mt, a_oa, a_ob, a_wd, a_tgt;
  logic [3:0]         a_xc;
  logic [CTRL_SZ-1:0] a_ctrl;
  logic               b_rdy, b_vld, b_exc, b_take;
  logic [31:0]        b_pc, b_pc4, b_ins, b_mt, b_oa, b_ob, b_wd, b_tgt;
  logic [3:0]         b_xc;
  logic [CTRL_SZ-1:0] b_ctrl;

  always #5 clk = ~clk;

  mirfak_id_stage_hs #(.NFWD(NFWD), .HAS_RVC(0), .BJ_REG(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_ready_o(a_rdy),
    .id_pc_i(pc), .id_pc4_i(pc4), .id_instruction_i(instr),
    .id_if_exception_i(if_exc), .id_if_xcause_i(if_xc), .id_control_i(ctrl),
    .id_fwd_a_sel_i(sel_a), .id_fwd_b_sel_i(sel_b), .fwd_data_i(fwd),
    .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata), .wb_wen_i(wb_wen),
    .idex_clear_i(clear), .ex_valid_o(a_vld), .ex_ready_i(ex_ready),
    .ex_pc_o(a_pc), .ex_pc4_o(a_pc4), .ex_instruction_o(a_ins), .ex_mtval_o(a_mt),
    .ex_operand_a_o(a_oa), .ex_operand_b_o(a_ob), .ex_lsu_wdata_o(a_wd),
    .ex_exception_o(a_exc), .ex_xcause_o(a_xc), .ex_control_o(a_ctrl),
    .take_branch_o(a_take), .pc_bj_target_o(a_tgt));

  mirfak_id_stage_hs #(.NFWD(NFWD), .HAS_RVC(1), .BJ_REG(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_ready_o(b_rdy),
    .id_pc_i(pc), .id_pc4_i(pc4), .id_instruction_i(instr),
    .id_if_exception_i(if_exc), .id_if_xcause_i(if_xc), .id_control_i(ctrl),
    .id_fwd_a_sel_i(sel_a), .id_fwd_b_sel_i(sel_b), .fwd_data_i(fwd),
    .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata), .wb_wen_i(wb_wen),
    .idex_clear_i(clear), .ex_valid_o(b_vld), .ex_ready_i(ex_ready),
    .ex_pc_o(b_pc), .ex_pc4_o(b_pc4), .ex_instruction_o(b_ins), .ex_mtval_o(b_mt),
    .ex_operand_a_o(b_oa), .ex_operand_b_o(b_ob), .ex_lsu_wdata_o(b_wd),
    .ex_exception_o(b_exc), .ex_xcause_o(b_xc), .ex_control_o(b_ctrl),
    .take_branch_o(b_take), .pc_bj_target_o(b_tgt));

  typedef struct {
    logic [31:0] pc, pc4, instr, opa, opb, wdata, tgt;
    logic [CTRL_SZ-1:0] ctrl;
    logic taken;
    logic exc0; logic [3:0] xc0; logic [31:0] mt0;
    logic exc1; logic [3:0] xc1; logic [31:0] mt1;
  } item_t;

  item_t       q[$];
  item_t       shown;
  logic [31:0] rf_m [32];
  logic        exp_take_a;
  logic [31:0] exp_tgt_a;
  int          n_chk = 0, n_fail = 0;

  int unsigned cur_kind;
  logic [4:0]  cur_rs1, cur_rs2, cur_rd;
  logic [2:0]  cur_f3;
  logic [31:0] cur_imm;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic item_t rst_item();
    item_t it;
    it = '{pc: '0, pc4: '0, instr: NOP, opa: '0, opb: '0, wdata: '0, tgt: '0,
           ctrl: '0, taken: 1'b0, exc0: 1'b0, xc0: '0, mt0: '0,
           exc1: 1'b0, xc1: '0, mt1: '0};
    return it;
  endfunction

  function automatic logic [31:0] opv(input logic [1:0] sel, input logic [4:0] r);
    case (sel)
      2'd1:    return fwd[31:0];
      2'd2:    return fwd[63:32];
      2'd3:    return fwd[95:64];
      default: return (r == 5'd0) ? 32'd0 : rf_m[r];
    endcase
  endfunction

  // Expected EX payload for the instruction currently presented, from ISA rules
  function automatic item_t model_item();
    item_t it;
    logic [31:0] a, b, t;
    logic mis;
    a = opv(sel_a, instr[19:15]);
    b = opv(sel_b, instr[24:20]);
    it = rst_item();
    it.pc = pc; it.pc4 = pc4; it.instr = instr; it.ctrl = ctrl; it.wdata = b;
    case (cur_kind)
      0, 2:    begin it.opa = a;   it.opb = cur_imm; end
      3:       begin it.opa = 0;   it.opb = cur_imm; end
      4:       begin it.opa = pc;  it.opb = cur_imm; end
      5: begin
        it.opa = a; it.opb = b; it.tgt = pc + cur_imm;
        case (cur_f3)
          3'd0: it.taken = (a == b);
          3'd1: it.taken = (a != b);
          3'd4: it.taken = ($signed(a) < $signed(b));
          3'd5: it.taken = !($signed(a) < $signed(b));
          3'd6: it.taken = (a < b);
          default: it.taken = !(a < b);
        endcase
      end
      6:       begin it.opa = pc; it.opb = 4; it.taken = 1; it.tgt = pc + cur_imm; end
      7:       begin it.opa = pc; it.opb = 4; it.taken = 1; it.tgt = (a + cur_imm) & 32'hFFFF_FFFE; end
      default: begin it.opa = a;  it.opb = b; end
    endcase
    for (int cfg = 0; cfg < 2; cfg++) begin
      logic e; logic [3:0] x; logic [31:0] m;
      t = it.tgt;
      mis = it.taken && ((cfg == 1) ? (t[0] == 1'b1) : (t % 4 != 0));
      if (if_exc)              begin e = 1; x = if_xc;                  m = pc;    end
      else if (mis)            begin e = 1; x = E_INST_ADDR_MISALIGNED; m = t;     end
      else if (cur_kind == 8)  begin e = 1; x = E_ILLEGAL_INST;         m = instr; end
      else                     begin e = 0; x = 0;                      m = 0;     end
      if (cfg == 0) begin it.exc0 = e; it.xc0 = x; it.mt0 = m; end
      else          begin it.exc1 = e; it.xc1 = x; it.mt1 = m; end
    end
    return it;
  endfunction

  task automatic rand_fields(input int unsigned kind);
    logic [31:0] r;
    r = $urandom;
    cur_kind = kind;
    cur_rs1 = 5'($urandom); cur_rs2 = 5'($urandom); cur_rd = 5'($urandom);
    case ($urandom_range(0, 5))
      0: cur_f3 = 3'd0; 1: cur_f3 = 3'd1; 2: cur_f3 = 3'd4;
      3: cur_f3 = 3'd5; 4: cur_f3 = 3'd6; default: cur_f3 = 3'd7;
    endcase
    case (kind)
      0, 2, 7: cur_imm = 32'($signed(r[11:0]));
      3, 4:    cur_imm = {r[31:12], 12'b0};
      5:       cur_imm = 32'($signed({r[12:1], 1'b0}));
      6:       cur_imm = 32'($signed({r[20:1], 1'b0}));
      default: cur_imm = '0;
    endcase
    pc = $urandom & 32'hFFFF_FFFE;
    sel_a = 2'($urandom_range(0, NFWD));
    sel_b = 2'($urandom_range(0, NFWD));
    fwd = {$urandom, $urandom, $urandom};
    if_exc = ($urandom_range(0, 9) == 0);
    if_xc = 4'($urandom);
  endtask

  // Encode the chosen fields into an instruction word and its control word
  task automatic apply();
    ctrl_t c;
    logic [31:0] m;
    m = cur_imm;
    c = '0;
    c.alu_op = 4'($urandom);
    c.a_sel = A_REG; c.b_sel = B_REG; c.imm_sel = IMM_I;
    case (cur_kind)
      0: begin instr = {m[11:0], cur_rs1, 3'b000, cur_rd, 7'b0010011}; c.b_sel = B_IMM; end
      1: instr = {7'b0, cur_rs2, cur_rs1, 3'b000, cur_rd, 7'b0110011};
      2: begin instr = {m[11:5], cur_rs2, cur_rs1, 3'b010, m[4:0], 7'b0100011};
               c.imm_sel = IMM_S; c.b_sel = B_IMM; end
      3: begin instr = {m[31:12], cur_rd, 7'b0110111}; c.imm_sel = IMM_U;
               c.a_sel = A_ZERO; c.b_sel = B_IMM; end
      4: begin instr = {m[31:12], cur_rd, 7'b0010111}; c.imm_sel = IMM_U;
               c.a_sel = A_PC; c.b_sel = B_IMM; end
      5: begin instr = {m[12], m[10:5], cur_rs2, cur_rs1, cur_f3, m[4:1], m[11], 7'b1100011};
               c.imm_sel = IMM_B; c.branch = 1'b1; end
      6: begin instr = {m[20], m[10:1], m[11], m[19:12], cur_rd, 7'b1101111};
               c.imm_sel = IMM_J; c.jal = 1'b1; c.a_sel = A_PC; c.b_sel = B_4; end
      7: begin instr = {m[11:0], cur_rs1, 3'b000, cur_rd, 7'b1100111};
               c.jalr = 1'b1; c.a_sel = A_PC; c.b_sel = B_4; end
      default: begin instr = {7'h7f, cur_rs2, cur_rs1, 3'b111, cur_rd, 7'b0000000};
               c.illegal = 1'b1; end
    endcase
    ctrl = c;
    pc4 = pc + 4;
    assert (32'(sel_a) <= NFWD && 32'(sel_b) <= NFWD);
  endtask

  task automatic chk_dut(input string p, input int cfg, input logic v, input logic r,
                         input logic [31:0] o_pc, input logic [31:0] o_pc4,
                         input logic [31:0] o_ins, input logic [31:0] o_mt,
                         input logic [31:0] o_oa, input logic [31:0] o_ob,
                         input logic [31:0] o_wd, input logic o_exc,
                         input logic [3:0] o_xc, input logic [CTRL_SZ-1:0] o_ctrl);
    check({p, "_ex_valid"}, 32'(v), 32'(q.size() > 0));
    check({p, "_id_ready"}, 32'(r), 32'(q.size() < 2));
    check({p, "_pc"}, o_pc, shown.pc);
    check({p, "_pc4"}, o_pc4, shown.pc4);
    check({p, "_instr"}, o_ins, shown.instr);
    check({p, "_op_a"}, o_oa, shown.opa);
    check({p, "_op_b"}, o_ob, shown.opb);
    check({p, "_lsu_wdata"}, o_wd, shown.wdata);
    check({p, "_control"}, 32'(o_ctrl), 32'(shown.ctrl));
    check({p, "_exception"}, 32'(o_exc), 32'((cfg == 0) ? shown.exc0 : shown.exc1));
    check({p, "_xcause"}, 32'(o_xc), 32'((cfg == 0) ? shown.xc0 : shown.xc1));
    check({p, "_mtval"}, o_mt, (cfg == 0) ? shown.mt0 : shown.mt1);
  endtask

  // One clock: called just after a falling edge with inputs already driven
  task automatic step();
    item_t it;
    logic acc, hand, fire;
    #1;
    it   = model_item();
    acc  = id_valid && (q.size() < 2);
    fire = acc && it.taken && !clear && !rst;
    hand = (q.size() > 0) && ex_ready;
    check("b_take", 32'(b_take), 32'(fire));
    check("b_target", b_tgt, fire ? it.tgt : 32'd0);
    @(posedge clk);
    if (rst) begin
      q.delete();
      shown = rst_item();
      exp_take_a = 1'b0;
      exp_tgt_a = '0;
      foreach (rf_m[i]) rf_m[i] = '0;
    end else begin
      if (clear) q.delete();
      else begin
        if (hand) void'(q.pop_front());
        if (acc) q.push_back(it);
      end
      exp_take_a = fire;
      if (fire) exp_tgt_a = it.tgt;
      if (wb_wen && wb_waddr != 5'd0) rf_m[wb_waddr] = wb_wdata;
    end
    if (q.size() > 0) shown = q[0];
    @(negedge clk);
    chk_dut("a", 0, a_vld, a_rdy, a_pc, a_pc4, a_ins, a_mt, a_oa, a_ob, a_wd, a_exc, a_xc, a_ctrl);
    chk_dut("b", 1, b_vld, b_rdy, b_pc, b_pc4, b_ins, b_mt, b_oa, b_ob, b_wd, b_exc, b_xc, b_ctrl);
    check("a_take", 32'(a_take), 32'(exp_take_a));
    check("a_target", a_tgt, exp_tgt_a);
  endtask

  task automatic idle();
    id_valid = 0; clear = 0; wb_wen = 0;
  endtask

  task automatic push(input int unsigned kind);
    rand_fields(kind); if_exc = 0; apply(); id_valid = 1;
  endtask

  initial begin
    rst = 1; id_valid = 0; clear = 0; ex_ready = 1; wb_wen = 0; wb_waddr = 0; wb_wdata = 0;
    rand_fields(0); apply();
    shown = rst_item(); exp_take_a = 0; exp_tgt_a = 0;
    foreach (rf_m[i]) rf_m[i] = '0;
    step(); step();
    rst = 0;

    // ADDI x1, x0, 5
    push(0); cur_rs1 = 0; cur_rd = 1; cur_imm = 5; sel_a = 0; apply();
    step(); idle(); step();

    // preload x5 and x7
    wb_wen = 1; wb_waddr = 5; wb_wdata = 32'hDEAD_BEEF; step();
    wb_waddr = 7; wb_wdata = 32'h0000_1002; step();
    wb_wen = 0;

    // three offers against a stalled EX, then drain
    ex_ready = 0;
    for (int i = 0; i < 3; i++) begin push(i % 2); step(); end
    ex_ready = 1; idle();
    for (int i = 0; i < 3; i++) step();

    // BEQ with rs1 from forwarding source 3 against x5: equal, then unequal
    for (int i = 0; i < 2; i++) begin
      push(5); cur_f3 = 0; cur_rs1 = 9; cur_rs2 = 5; sel_a = 3; sel_b = 0; apply();
      fwd[95:64] = (i == 0) ? 32'hDEAD_BEEF : 32'hDEAD_BEEE;
      step();
    end
    idle(); step(); step();

    // JALR to x7 (0x1002): misaligned only without RVC
    push(7); cur_rs1 = 7; cur_imm = 0; sel_a = 0; apply();
    step(); idle(); step(); step();

    // flush while a taken JAL is being accepted behind a stalled entry
    ex_ready = 0;
    push(0); step();
    push(6); clear = 1; step();
    idle(); step();
    // flush with both entries occupied
    push(1); step(); push(0); step(); push(0); clear = 1; step();
    idle(); step();

    // reset in the middle of a stall
    push(0); step(); push(5); step();
    idle(); rst = 1; step(); rst = 0; step();
    ex_ready = 1;

    for (int i = 0; i < 500; i++) begin
      rand_fields($urandom_range(0, 8));
      apply();
      id_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 2) != 0);
      clear    = ($urandom_range(0, 24) == 0);
      wb_wen   = $urandom_range(0, 1);
      wb_waddr = 5'($urandom);
      wb_wdata = $urandom;
      rst      = (i == 250);
      if (rst) begin id_valid = 0; clear = 0; end
      step();
    end
    rst = 0; idle(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
